// File: rtl/multicycle_control.sv
// multicycle_control: state sequencer for a multi-cycle MIPS datapath with a
// shared instruction/data memory. Control outputs decode from the current
// state, except IRWrite/PCWrite in FETCH, which also follow memReady.
// A retired-instruction counter is kept for bring-up.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             memReady,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUOp,
  output logic             illegalOp,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  state_t           state_reg;
  logic [CNT_W-1:0] retired_reg;

  // State transitions and retired-instruction counting; reset wins over all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_FETCH;
      retired_reg <= '0;
    end else begin
      case (state_reg)
        S_FETCH:  if (memReady) state_reg <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_RTYPE:      state_reg <= S_EXEC;
            OP_ADDI:       state_reg <= S_ADDIEX;
            OP_LW, OP_SW:  state_reg <= S_MEMADR;
            OP_BEQ:        state_reg <= S_BRANCH;
            OP_J:          state_reg <= S_JUMP;
            default:       state_reg <= S_ILLEGAL;
          endcase
        end
        S_MEMADR: state_reg <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (memReady) state_reg <= S_MEMWB;
        S_MEMWR: begin
          if (memReady) begin
            state_reg   <= S_FETCH;
            retired_reg <= retired_reg + CNT_W'(1);
          end
        end
        S_EXEC:   state_reg <= S_RWB;
        S_ADDIEX: state_reg <= S_ADDIWB;
        S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
          state_reg   <= S_FETCH;
          retired_reg <= retired_reg + CNT_W'(1);
        end
        // ILLEGAL and the unused codes 13-15 all fall back to FETCH.
        default:  state_reg <= S_FETCH;
      endcase
    end
  end

  // Control decode from the current state; anything not set stays 0.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    illegalOp   = 1'b0;
    case (state_reg)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = memReady;
        PCWrite = memReady;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_ADDIWB:  RegWrite  = 1'b1;
      S_ILLEGAL: illegalOp = 1'b1;
      default: ;
    endcase
  end

  assign state   = state_reg;
  assign retired = retired_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed per-cycle checks of state code and the full
// control word against hand-derived values for each instruction class.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        memReady;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic        IRWrite, RegDst, RegWrite, ALUSrcA, illegalOp;
  logic [1:0]  ALUSrcB, PCSource, ALUOp;
  logic [3:0]  state;
  logic [31:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  // Control word order:
  // PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite RegDst RegWrite ALUSrcA
  // | ALUSrcB | PCSource | ALUOp | illegalOp
  localparam logic [16:0] C_FETCH_RDY = 17'b1001001000_01_00_00_0;
  localparam logic [16:0] C_FETCH_WT  = 17'b0001000000_01_00_00_0;
  localparam logic [16:0] C_DECODE    = 17'b0000000000_11_00_00_0;
  localparam logic [16:0] C_MEMADR    = 17'b0000000001_10_00_00_0;
  localparam logic [16:0] C_MEMRD     = 17'b0011000000_00_00_00_0;
  localparam logic [16:0] C_MEMWB     = 17'b0000010010_00_00_00_0;
  localparam logic [16:0] C_MEMWR     = 17'b0010100000_00_00_00_0;
  localparam logic [16:0] C_EXEC      = 17'b0000000001_00_00_10_0;
  localparam logic [16:0] C_RWB       = 17'b0000000110_00_00_00_0;
  localparam logic [16:0] C_BRANCH    = 17'b0100000001_00_01_01_0;
  localparam logic [16:0] C_JUMP      = 17'b1000000000_00_10_00_0;
  localparam logic [16:0] C_ADDIEX    = 17'b0000000001_10_00_00_0;
  localparam logic [16:0] C_ADDIWB    = 17'b0000000010_00_00_00_0;
  localparam logic [16:0] C_ILLEGAL   = 17'b0000000000_00_00_00_1;

  logic [16:0] ctrl;
  assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                 RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, illegalOp};

  multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .memReady(memReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .illegalOp(illegalOp), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: apply memReady, let it settle, check state/control/counter, then clock.
  task automatic cyc(input string tag, input logic mr, input logic [3:0] exp_state,
                     input logic [16:0] exp_ctrl, input logic [31:0] exp_ret);
    memReady = mr;
    #1;
    check({tag, ".state"}, 32'(state), 32'(exp_state));
    check({tag, ".ctrl"}, 32'(ctrl), 32'(exp_ctrl));
    check({tag, ".retired"}, retired, exp_ret);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    opcode   = 6'h00;
    memReady = 1'b1;
    @(posedge clk);
    #1;
    do_reset();
    memReady = 1'b0;
    #1;
    check("reset.state", 32'(state), 32'd0);
    check("reset.retired", retired, 32'd0);
    check("reset.ctrl", 32'(ctrl), 32'(C_FETCH_WT));

    // R-type: 0,1,6,7,0
    opcode = 6'h00;
    cyc("rtype.fetch", 1'b1, 4'd0, C_FETCH_RDY, 32'd0);
    cyc("rtype.decode", 1'b0, 4'd1, C_DECODE, 32'd0);
    cyc("rtype.exec", 1'b0, 4'd6, C_EXEC, 32'd0);
    cyc("rtype.rwb", 1'b0, 4'd7, C_RWB, 32'd0);
    $display("txn rtype: retired=%0d state=%0d", retired, state);

    // lw with 3 wait cycles in MEMRD: 0,1,2,3,3,3,3,4,0
    opcode = 6'h23;
    cyc("lw.fetch", 1'b1, 4'd0, C_FETCH_RDY, 32'd1);
    cyc("lw.decode", 1'b1, 4'd1, C_DECODE, 32'd1);
    cyc("lw.memadr", 1'b1, 4'd2, C_MEMADR, 32'd1);
    for (int i = 0; i < 3; i++)
      cyc("lw.memrd_wait", 1'b0, 4'd3, C_MEMRD, 32'd1);
    cyc("lw.memrd", 1'b1, 4'd3, C_MEMRD, 32'd1);
    cyc("lw.memwb", 1'b0, 4'd4, C_MEMWB, 32'd1);
    $display("txn lw: retired=%0d state=%0d", retired, state);

    // sw with 2 wait cycles in FETCH and 1 in MEMWR
    opcode = 6'h2B;
    cyc("sw.fetch_wait", 1'b0, 4'd0, C_FETCH_WT, 32'd2);
    cyc("sw.fetch_wait", 1'b0, 4'd0, C_FETCH_WT, 32'd2);
    cyc("sw.fetch", 1'b1, 4'd0, C_FETCH_RDY, 32'd2);
    cyc("sw.decode", 1'b0, 4'd1, C_DECODE, 32'd2);
    cyc("sw.memadr", 1'b0, 4'd2, C_MEMADR, 32'd2);
    cyc("sw.memwr_wait", 1'b0, 4'd5, C_MEMWR, 32'd2);
    cyc("sw.memwr", 1'b1, 4'd5, C_MEMWR, 32'd2);
    $display("txn sw: retired=%0d state=%0d", retired, state);

    // beq then j, 3 cycles each
    opcode = 6'h04;
    cyc("beq.fetch", 1'b1, 4'd0, C_FETCH_RDY, 32'd3);
    cyc("beq.decode", 1'b1, 4'd1, C_DECODE, 32'd3);
    cyc("beq.branch", 1'b0, 4'd8, C_BRANCH, 32'd3);
    $display("txn beq: retired=%0d state=%0d", retired, state);
    opcode = 6'h02;
    cyc("j.fetch", 1'b1, 4'd0, C_FETCH_RDY, 32'd4);
    cyc("j.decode", 1'b1, 4'd1, C_DECODE, 32'd4);
    cyc("j.jump", 1'b0, 4'd9, C_JUMP, 32'd4);
    $display("txn j: retired=%0d state=%0d", retired, state);

    // addi: 0,1,10,11,0
    opcode = 6'h08;
    cyc("addi.fetch", 1'b1, 4'd0, C_FETCH_RDY, 32'd5);
    cyc("addi.decode", 1'b1, 4'd1, C_DECODE, 32'd5);
    cyc("addi.ex", 1'b1, 4'd10, C_ADDIEX, 32'd5);
    cyc("addi.wb", 1'b1, 4'd11, C_ADDIWB, 32'd5);
    $display("txn addi: retired=%0d state=%0d", retired, state);

    // illegal: pulse for one cycle, counter unchanged
    opcode = 6'h3F;
    cyc("ill.fetch", 1'b1, 4'd0, C_FETCH_RDY, 32'd6);
    cyc("ill.decode", 1'b1, 4'd1, C_DECODE, 32'd6);
    cyc("ill.illegal", 1'b1, 4'd12, C_ILLEGAL, 32'd6);
    cyc("ill.after", 1'b0, 4'd0, C_FETCH_WT, 32'd6);
    $display("txn illegal: retired=%0d state=%0d", retired, state);

    // reset in the middle of a MEMWR wait
    opcode = 6'h2B;
    cyc("swrst.fetch", 1'b1, 4'd0, C_FETCH_RDY, 32'd6);
    cyc("swrst.decode", 1'b1, 4'd1, C_DECODE, 32'd6);
    cyc("swrst.memadr", 1'b1, 4'd2, C_MEMADR, 32'd6);
    memReady = 1'b0;
    #1;
    check("swrst.memwr_state", 32'(state), 32'd5);
    check("swrst.memwr_we", 32'(MemWrite), 32'd1);
    do_reset();
    #1;
    check("swrst.after_state", 32'(state), 32'd0);
    check("swrst.after_retired", retired, 32'd0);
    check("swrst.after_we", 32'(MemWrite), 32'd0);
    check("swrst.after_ctrl", 32'(ctrl), 32'(C_FETCH_WT));
    $display("txn sw-reset: retired=%0d state=%0d", retired, state);

    // counter resumes from zero
    opcode = 6'h00;
    cyc("post.fetch", 1'b1, 4'd0, C_FETCH_RDY, 32'd0);
    cyc("post.decode", 1'b1, 4'd1, C_DECODE, 32'd0);
    cyc("post.exec", 1'b1, 4'd6, C_EXEC, 32'd0);
    cyc("post.rwb", 1'b1, 4'd7, C_RWB, 32'd0);
    memReady = 1'b0;
    #1;
    check("post.retired", retired, 32'd1);
    check("post.state", 32'(state), 32'd0);
    $display("txn rtype-after-reset: retired=%0d state=%0d", retired, state);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
